// File: rtl/explosion_ctrl_if.sv
// rtl/explosion_ctrl_if.sv - bomb-request, block-map and explosion-map signal bundle
interface explosion_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [3:0]        bomb_row;
    logic [3:0]        bomb_col;
    logic [2:0]        range;
    logic              busy;
    logic [ADDR_W-1:0] blk_addr;
    logic [1:0]        blk_data;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_data;
    logic              soft_hit;
    logic [ADDR_W-1:0] soft_addr;
    logic              active;
    logic [1:0]        anim_frame;
    logic              done;

    modport master (
        output start, bomb_row, bomb_col, range, blk_data,
        input  busy, blk_addr, exp_we, exp_addr, exp_data,
        input  soft_hit, soft_addr, active, anim_frame, done
    );

    modport slave (
        input  start, bomb_row, bomb_col, range, blk_data,
        output busy, blk_addr, exp_we, exp_addr, exp_data,
        output soft_hit, soft_addr, active, anim_frame, done
    );
endinterface

// File: rtl/explosion_ctrl.sv
// rtl/explosion_ctrl.sv - one bomb detonation: probe reach, set map, hold, clear
module explosion_ctrl #(
    parameter int GRID_COLS    = 15,
    parameter int GRID_ROWS    = 11,
    parameter int ADDR_W       = 8,
    parameter int FRAME_CYCLES = 6250000
) (
    input  logic            clk,
    input  logic            reset_n,
    explosion_ctrl_if.slave bus
);

    localparam int SUB_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CENTER, S_PROBE_RD, S_PROBE_EV, S_HOLD, S_CLEAR, S_DONE
    } state_t;

    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d;
    logic [2:0] k_q, k_d;
    logic [3:0] row_q, row_d, col_q, col_d;
    logic [2:0] range_q, range_d;
    logic [2:0] reach_q [4];
    logic [2:0] reach_d [4];

    logic [SUB_W-1:0] sub_q;
    logic [1:0]       frame_q;
    logic             sub_last, hold_last;

    logic signed [4:0] row_s, col_s, k_s, tgt_row, tgt_col;
    logic              off_grid;
    logic [ADDR_W-1:0] tgt_addr;

    logic              end_dir;
    logic              nxt_found;
    dir_t              nxt_dir;

    // Target tile for (dir, k); k=0 yields the bomb centre. 5-bit signed math
    // flags underflow, and any overshoot past 15 wraps negative so still reads off-grid.
    always_comb begin
        row_s   = signed'({1'b0, row_q});
        col_s   = signed'({1'b0, col_q});
        k_s     = signed'({2'b00, k_q});
        tgt_row = row_s;
        tgt_col = col_s;
        case (dir_q)
            D_UP:    tgt_row = row_s - k_s;
            D_DOWN:  tgt_row = row_s + k_s;
            D_LEFT:  tgt_col = col_s - k_s;
            default: tgt_col = col_s + k_s;
        endcase
        off_grid = (tgt_row < 0) || (int'(tgt_row) >= GRID_ROWS) ||
                   (tgt_col < 0) || (int'(tgt_col) >= GRID_COLS);
        tgt_addr = ADDR_W'(unsigned'(tgt_row)) * ADDR_W'(GRID_COLS) +
                   ADDR_W'(unsigned'(tgt_col));
    end

    // Clear phase: next direction after the current one that has a non-zero reach.
    always_comb begin
        nxt_found = 1'b0;
        nxt_dir   = dir_q;
        for (int d = 3; d >= 0; d--) begin
            if ((d > int'(dir_q)) && (reach_q[d] != 3'd0)) begin
                nxt_found = 1'b1;
                nxt_dir   = dir_t'(2'(d));
            end
        end
    end

    assign sub_last  = (sub_q == SUB_W'(FRAME_CYCLES - 1));
    assign hold_last = sub_last && (frame_q == 2'd3);

    // Next-state, datapath updates and all outputs.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        k_d      = k_q;
        row_d    = row_q;
        col_d    = col_q;
        range_d  = range_q;
        reach_d  = reach_q;
        end_dir  = 1'b0;

        bus.busy       = 1'b1;
        bus.blk_addr   = '0;
        bus.exp_we     = 1'b0;
        bus.exp_addr   = '0;
        bus.exp_data   = 1'b0;
        bus.soft_hit   = 1'b0;
        bus.soft_addr  = '0;
        bus.active     = 1'b0;
        bus.anim_frame = 2'd0;
        bus.done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    row_d   = bus.bomb_row;
                    col_d   = bus.bomb_col;
                    range_d = bus.range;
                    dir_d   = D_UP;
                    k_d     = 3'd0;
                    reach_d = '{default: 3'd0};
                    state_d = S_CENTER;
                end
            end
            S_CENTER: begin
                bus.exp_we   = 1'b1;
                bus.exp_addr = tgt_addr;
                bus.exp_data = 1'b1;
                dir_d        = D_UP;
                k_d          = 3'd1;
                state_d      = (range_q == 3'd0) ? S_HOLD : S_PROBE_RD;
            end
            S_PROBE_RD: begin
                if (off_grid) begin
                    reach_d[dir_q] = k_q - 3'd1;
                    end_dir        = 1'b1;
                end else begin
                    bus.blk_addr = tgt_addr;
                    state_d      = S_PROBE_EV;
                end
            end
            S_PROBE_EV: begin
                if (bus.blk_data[1]) begin
                    reach_d[dir_q] = k_q - 3'd1;
                    end_dir        = 1'b1;
                end else begin
                    bus.exp_we   = 1'b1;
                    bus.exp_addr = tgt_addr;
                    bus.exp_data = 1'b1;
                    if (bus.blk_data[0]) begin
                        bus.soft_hit   = 1'b1;
                        bus.soft_addr  = tgt_addr;
                        reach_d[dir_q] = k_q;
                        end_dir        = 1'b1;
                    end else if (k_q == range_q) begin
                        reach_d[dir_q] = k_q;
                        end_dir        = 1'b1;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = S_PROBE_RD;
                    end
                end
            end
            S_HOLD: begin
                bus.active     = 1'b1;
                bus.anim_frame = frame_q;
                if (hold_last) begin
                    dir_d   = D_UP;
                    k_d     = 3'd0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.exp_we   = 1'b1;
                bus.exp_addr = tgt_addr;
                bus.exp_data = 1'b0;
                if (k_q < reach_q[dir_q]) begin
                    k_d = k_q + 3'd1;
                end else if (nxt_found) begin
                    dir_d = nxt_dir;
                    k_d   = 3'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus.busy = 1'b0;
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (end_dir) begin
            k_d = 3'd1;
            if (dir_q == D_RIGHT) begin
                state_d = S_HOLD;
            end else begin
                dir_d   = dir_t'(dir_q + 2'd1);
                state_d = S_PROBE_RD;
            end
        end
    end

    // State and latched detonation parameters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dir_q   <= D_UP;
            k_q     <= 3'd0;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            range_q <= 3'd0;
            reach_q <= '{default: 3'd0};
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            range_q <= range_d;
            reach_q <= reach_d;
        end
    end

    // Hold timer split into frame index and cycles-within-frame; idles at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sub_q   <= '0;
            frame_q <= 2'd0;
        end else if (state_q == S_HOLD) begin
            if (sub_last) begin
                sub_q   <= '0;
                frame_q <= frame_q + 2'd1;
            end else begin
                sub_q <= sub_q + 1'b1;
            end
        end else begin
            sub_q   <= '0;
            frame_q <= 2'd0;
        end
    end

endmodule

// File: tb/tb_explosion_ctrl.sv
// tb/tb_explosion_ctrl.sv - scoreboard bench for explosion_ctrl
module tb_explosion_ctrl;

    localparam int COLS  = 15;
    localparam int ROWS  = 11;
    localparam int AW    = 8;
    localparam int FC    = 3;
    localparam int BOUND = 2000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    explosion_ctrl_if #(.ADDR_W(AW)) bus ();

    explosion_ctrl #(
        .GRID_COLS(COLS), .GRID_ROWS(ROWS), .ADDR_W(AW), .FRAME_CYCLES(FC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] bmap [0:COLS*ROWS-1];
    int exp_q[$];
    int soft_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // block-map memory with one cycle read latency
    always @(posedge clk)
        bus.blk_data <= (int'(bus.blk_addr) < COLS*ROWS) ? bmap[bus.blk_addr] : 2'b11;

    // write / soft-hit monitor popping the scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.exp_we) begin
                int ev;
                ev = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check_eq("exp_write", {bus.exp_data, bus.exp_addr}, ev);
            end
            if (bus.soft_hit) begin
                int sv;
                sv = (soft_q.size() > 0) ? soft_q.pop_front() : -1;
                check_eq("soft_addr", bus.soft_addr, sv);
            end
        end
    end

    task automatic model(input int r, input int c, input int rng,
                         output int set_cyc, output int clr_cyc);
        int reach[4];
        int dr[4];
        int dc[4];
        int tr, tc, a;
        dr = '{-1, 1, 0, 0};
        dc = '{0, 0, -1, 1};
        exp_q.push_back(256 + r*COLS + c);
        set_cyc = 1;
        for (int d = 0; d < 4; d++) begin
            reach[d] = 0;
            for (int k = 1; k <= rng; k++) begin
                tr = r + dr[d]*k;
                tc = c + dc[d]*k;
                if (tr < 0 || tr >= ROWS || tc < 0 || tc >= COLS) begin
                    set_cyc += 1;
                    break;
                end
                set_cyc += 2;
                a = tr*COLS + tc;
                if (bmap[a] >= 2) break;
                exp_q.push_back(256 + a);
                reach[d] = k;
                if (bmap[a] == 1) begin
                    soft_q.push_back(a);
                    break;
                end
            end
        end
        exp_q.push_back(r*COLS + c);
        clr_cyc = 1;
        for (int d = 0; d < 4; d++) begin
            for (int k = 1; k <= reach[d]; k++) begin
                exp_q.push_back((r + dr[d]*k)*COLS + (c + dc[d]*k));
                clr_cyc++;
            end
        end
    endtask

    task automatic run_seq(input int r, input int c, input int rng,
                           input int pulse_set, input int pulse_hold);
        int set_exp, clr_exp;
        int set_n, hold_n, clr_n, cyc;
        bit seen_done;
        model(r, c, rng, set_exp, clr_exp);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.bomb_row = 4'(r);
        bus.bomb_col = 4'(c);
        bus.range    = 3'(rng);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.bomb_row = 4'($urandom_range(0, 15));
        bus.bomb_col = 4'($urandom_range(0, 15));
        bus.range    = 3'($urandom_range(0, 7));
        set_n = 0; hold_n = 0; clr_n = 0; cyc = 0; seen_done = 1'b0;
        while (!seen_done && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (bus.done) begin
                seen_done = 1'b1;
                check_eq("busy_at_done", bus.busy, 0);
            end else if (bus.active) begin
                check_eq("anim_frame", bus.anim_frame, hold_n / FC);
                if (hold_n == pulse_hold) bus.start = 1'b1;
                hold_n++;
            end else if (bus.busy) begin
                if (hold_n == 0) begin
                    set_n++;
                    if (set_n == pulse_set) bus.start = 1'b1;
                end else begin
                    clr_n++;
                end
            end
        end
        bus.start = 1'b0;
        check_eq("done_seen", seen_done, 1);
        check_eq("set_cycles", set_n, set_exp);
        check_eq("hold_cycles", hold_n, 4*FC);
        check_eq("clear_cycles", clr_n, clr_exp);
        check_eq("writes_drained", exp_q.size(), 0);
        check_eq("soft_drained", soft_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_exp_we"}, bus.exp_we, 0);
        check_eq({tag, "_active"}, bus.active, 0);
        check_eq({tag, "_done"}, bus.done, 0);
        check_eq({tag, "_soft_hit"}, bus.soft_hit, 0);
        check_eq({tag, "_anim"}, bus.anim_frame, 0);
        check_eq({tag, "_blk_addr"}, bus.blk_addr, 0);
        check_eq({tag, "_exp_addr"}, bus.exp_addr, 0);
    endtask

    initial begin
        int sd, cd, cyc;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.bomb_row = 4'd0;
        bus.bomb_col = 4'd0;
        bus.range    = 3'd0;
        for (int i = 0; i < COLS*ROWS; i++) bmap[i] = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // all-empty map, range 2
        run_seq(5, 7, 2, -1, -1);

        // soft above, hard to the right
        bmap[5*COLS + 8] = 2'b10;
        bmap[3*COLS + 7] = 2'b01;
        run_seq(5, 7, 3, -1, -1);

        // corner: up and left are off-grid immediately
        for (int i = 0; i < COLS*ROWS; i++) bmap[i] = 2'b00;
        run_seq(0, 0, 2, -1, -1);

        // range 0: centre only
        run_seq(3, 4, 0, -1, -1);

        // stray starts during probe and hold, then back-to-back start after done
        run_seq(5, 7, 2, 3, 5);
        for (int i = 0; i < COLS*ROWS; i++) bmap[i] = 2'($urandom_range(0, 3));
        run_seq(10, 14, 7, -1, -1);
        run_seq(6, 2, 7, -1, -1);

        // reset in the middle of hold
        model(2, 2, 1, sd, cd);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.bomb_row = 4'd2;
        bus.bomb_col = 4'd2;
        bus.range    = 3'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.active && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("hold_reached", bus.active, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midhold_reset");
        exp_q.delete();
        soft_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        run_seq(4, 6, 3, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
